// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline WB stage always wins, and
// mult/div results wait in a one-entry holding buffer. A starvation counter
// escalates to a stall request. RAW/WAW hazards against the buffered
// destination are flagged for the decode interlock.
module wb_port_arbiter #(
    parameter int unsigned DW           = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_waddr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          md_valid,
    input  logic [AW-1:0] md_waddr,
    input  logic [DW-1:0] md_wdata,
    output logic          md_ready,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [AW-1:0] dst_addr,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          stall_req,
    output logic          raw_hazard,
    output logic          waw_hazard
);

    // The counter only needs to reach STARVE_LIMIT-1.
    localparam int unsigned CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CW-1:0] WaitLast = CW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {StIdle, StHeld, StForce} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] buf_waddr_q, buf_waddr_d;
    logic [DW-1:0] buf_wdata_q, buf_wdata_d;

    logic buf_valid;
    logic port_busy;
    logic md_xfer;

    assign buf_valid = (state_q != StIdle);
    // Writes to r0 never use the port, so they never block the buffer.
    assign port_busy = pipe_we && (pipe_waddr != '0);
    assign md_ready  = !reset && (state_q == StIdle);
    assign md_xfer   = md_valid && md_ready;
    assign stall_req = (state_q == StForce);

    assign raw_hazard = buf_valid && ((rs_addr == buf_waddr_q) || (rt_addr == buf_waddr_q));
    assign waw_hazard = buf_valid && (dst_addr == buf_waddr_q);

    // State, counter and holding-buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    // Next state: capture when blocked, drain when free, escalate on starvation.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;
        case (state_q)
            StIdle: begin
                // r0 results are accepted and dropped; unblocked ones bypass.
                if (md_xfer && port_busy && (md_waddr != '0)) begin
                    buf_waddr_d = md_waddr;
                    buf_wdata_d = md_wdata;
                    wait_cnt_d  = '0;
                    state_d     = StHeld;
                end
            end
            StHeld: begin
                if (!port_busy) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = StForce;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StForce: begin
                if (!port_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Write-port mux: pipeline, then buffer, then same-cycle md bypass.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!reset) begin
            if (port_busy) begin
                rf_we    = 1'b1;
                rf_waddr = pipe_waddr;
                rf_wdata = pipe_wdata;
            end else if (buf_valid) begin
                rf_we    = 1'b1;
                rf_waddr = buf_waddr_q;
                rf_wdata = buf_wdata_q;
            end else if (md_xfer && (md_waddr != '0)) begin
                rf_we    = 1'b1;
                rf_waddr = md_waddr;
                rf_wdata = md_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pipe_we = 1'b0;
    logic [AW-1:0] pipe_waddr = '0;
    logic [DW-1:0] pipe_wdata = '0;
    logic          md_valid = 1'b0;
    logic [AW-1:0] md_waddr = '0;
    logic [DW-1:0] md_wdata = '0;
    logic          md_ready;
    logic [AW-1:0] rs_addr = '0;
    logic [AW-1:0] rt_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stall_req;
    logic          raw_hazard;
    logic          waw_hazard;

    wb_port_arbiter #(
        .DW(DW),
        .AW(AW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pipe_we(pipe_we),
        .pipe_waddr(pipe_waddr),
        .pipe_wdata(pipe_wdata),
        .md_valid(md_valid),
        .md_waddr(md_waddr),
        .md_wdata(md_wdata),
        .md_ready(md_ready),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .dst_addr(dst_addr),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .stall_req(stall_req),
        .raw_hazard(raw_hazard),
        .waw_hazard(waw_hazard)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: pending results awaiting the port, and how many cycles the
    // oldest one has been refused the port since it was captured.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    entry_t pend[$];
    int     blocked = 0;
    bit     live = 1'b0;
    bit     md_pending = 1'b0;

    function automatic bit busy_now();
        return pipe_we && (pipe_waddr != 0);
    endfunction

    // Model update on each edge.
    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            blocked    = 0;
            md_pending = 1'b0;
            live       = 1'b1;
        end else if (live) begin
            md_pending = md_valid && (pend.size() != 0);
            if (pend.size() != 0) begin
                if (!busy_now()) pend.delete();
                else blocked++;
            end else if (md_valid && md_waddr != 0 && busy_now()) begin
                pend.push_back('{a: md_waddr, d: md_wdata});
                blocked = 0;
            end
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        logic          e_we, e_rdy, e_stall, e_raw, e_waw;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        bit            full;
        if (live) begin
            full  = (pend.size() != 0);
            e_rdy = !reset && !full;
            e_we  = 1'b0;
            e_wa  = '0;
            e_wd  = '0;
            if (!reset) begin
                if (busy_now()) begin
                    e_we = 1'b1; e_wa = pipe_waddr; e_wd = pipe_wdata;
                end else if (full) begin
                    e_we = 1'b1; e_wa = pend[0].a; e_wd = pend[0].d;
                end else if (md_valid && md_waddr != 0) begin
                    e_we = 1'b1; e_wa = md_waddr; e_wd = md_wdata;
                end
            end
            e_stall = full && (blocked >= LIMIT);
            e_raw   = full && (rs_addr == pend[0].a || rt_addr == pend[0].a);
            e_waw   = full && (dst_addr == pend[0].a);
            check("m_rf_we", 64'(rf_we), 64'(e_we));
            check("m_rf_waddr", 64'(rf_waddr), 64'(e_wa));
            check("m_rf_wdata", 64'(rf_wdata), 64'(e_wd));
            check("m_md_ready", 64'(md_ready), 64'(e_rdy));
            check("m_stall_req", 64'(stall_req), 64'(e_stall));
            check("m_raw", 64'(raw_hazard), 64'(e_raw));
            check("m_waw", 64'(waw_hazard), 64'(e_waw));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic we, input int a, input logic [DW-1:0] d);
        pipe_we    = we;
        pipe_waddr = AW'(a);
        pipe_wdata = d;
    endtask

    task automatic set_md(input logic v, input int a, input logic [DW-1:0] d);
        md_valid = v;
        md_waddr = AW'(a);
        md_wdata = d;
    endtask

    initial begin
        // Reset with a pending md result: nothing written, nothing accepted.
        reset = 1'b1;
        set_md(1'b1, 6, 32'h55);
        @(negedge clk);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_md_ready", 64'(md_ready), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        next_cycle();
        @(negedge clk);
        check("rst2_rf_we", 64'(rf_we), 64'd0);
        next_cycle();
        reset = 1'b0;
        set_md(1'b0, 0, 0);
        @(negedge clk);
        check("rst_rel_md_ready", 64'(md_ready), 64'd1);

        // Same-cycle bypass.
        next_cycle();
        set_md(1'b1, 5, 32'hDEADBEEF);
        @(negedge clk);
        check("byp_we", 64'(rf_we), 64'd1);
        check("byp_waddr", 64'(rf_waddr), 64'd5);
        check("byp_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        next_cycle();
        set_md(1'b0, 0, 0);
        @(negedge clk);
        check("byp_idle_ready", 64'(md_ready), 64'd1);

        // Collision: pipeline first, buffered result next cycle.
        next_cycle();
        set_pipe(1'b1, 3, 32'hAAAA);
        set_md(1'b1, 7, 32'h1234);
        @(negedge clk);
        check("buf_pipe_waddr", 64'(rf_waddr), 64'd3);
        next_cycle();
        set_pipe(1'b0, 0, 0);
        set_md(1'b0, 0, 0);
        @(negedge clk);
        check("buf_drain_waddr", 64'(rf_waddr), 64'd7);
        check("buf_drain_wdata", 64'(rf_wdata), 64'h1234);
        check("buf_drain_ready", 64'(md_ready), 64'd0);
        next_cycle();
        @(negedge clk);
        check("buf_after_ready", 64'(md_ready), 64'd1);

        // Starvation: stall_req rises after four blocked cycles in HELD.
        next_cycle();
        set_pipe(1'b1, 4, 32'h4444);
        set_md(1'b1, 9, 32'h9999);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            set_md(1'b0, 0, 0);
            @(negedge clk);
            check($sformatf("starve_quiet%0d", i), 64'(stall_req), 64'd0);
        end
        next_cycle();
        @(negedge clk);
        check("starve_stall", 64'(stall_req), 64'd1);
        check("starve_pipe_wins", 64'(rf_waddr), 64'd4);
        next_cycle();
        set_pipe(1'b0, 0, 0);
        @(negedge clk);
        check("starve_drain", 64'(rf_waddr), 64'd9);
        check("starve_drain_data", 64'(rf_wdata), 64'h9999);
        next_cycle();
        @(negedge clk);
        check("starve_clear", 64'(stall_req), 64'd0);

        // Hazards against the buffered destination.
        next_cycle();
        set_pipe(1'b1, 4, 32'h1);
        set_md(1'b1, 12, 32'hC);
        @(negedge clk);
        next_cycle();
        set_md(1'b0, 0, 0);
        rs_addr = 5'd12;
        @(negedge clk);
        check("haz_raw", 64'(raw_hazard), 64'd1);
        check("haz_waw_no", 64'(waw_hazard), 64'd0);
        next_cycle();
        rs_addr  = 5'd1;
        dst_addr = 5'd12;
        set_pipe(1'b0, 0, 0);
        @(negedge clk);
        check("haz_waw_drain", 64'(waw_hazard), 64'd1);
        next_cycle();
        rt_addr = 5'd12;
        @(negedge clk);
        check("haz_raw_gone", 64'(raw_hazard), 64'd0);
        check("haz_waw_gone", 64'(waw_hazard), 64'd0);
        rt_addr  = 5'd0;
        dst_addr = 5'd0;

        // r0 result: accepted, never written, even when blocked.
        next_cycle();
        set_pipe(1'b1, 2, 32'h2);
        set_md(1'b1, 0, 32'hF00D);
        @(negedge clk);
        check("r0_ready", 64'(md_ready), 64'd1);
        next_cycle();
        set_pipe(1'b0, 0, 0);
        @(negedge clk);
        check("r0_not_written", 64'(rf_we), 64'd0);
        check("r0_still_idle", 64'(md_ready), 64'd1);
        set_md(1'b0, 0, 0);

        // Reset while HELD drops the entry.
        next_cycle();
        set_pipe(1'b1, 4, 32'h4);
        set_md(1'b1, 9, 32'h99);
        @(negedge clk);
        next_cycle();
        set_md(1'b0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        next_cycle();
        reset = 1'b0;
        set_pipe(1'b0, 0, 0);
        @(negedge clk);
        check("rstheld_no_write", 64'(rf_we), 64'd0);
        check("rstheld_idle", 64'(md_ready), 64'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int heavy;
            next_cycle();
            heavy = ((c / 40) % 2 == 1) ? 90 : 35;
            reset = ($urandom_range(0, 99) == 0);
            set_pipe(($urandom_range(0, 99) < heavy), $urandom_range(0, 7), $urandom);
            if (!md_pending) begin
                set_md(($urandom_range(0, 99) < 50), $urandom_range(0, 7), $urandom);
            end
            rs_addr  = AW'($urandom_range(0, 7));
            rt_addr  = AW'($urandom_range(0, 7));
            dst_addr = AW'($urandom_range(0, 7));
        end
        next_cycle();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
